addsub_seq: RTL and testbench

//  Parametrised, multi-cycle add/subtract unit. Computes WIDTH-bit X+Y, X-Y, X+Y+cin or X-Y-~cin

---
 rtl/addsub_pkg.sv | 26 ++
 rtl/addsub_slice.sv | 39 +++
 rtl/addsub_seq.sv | 152 +++++++++++++++
 tb/tb_addsub_seq.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : addsub_pkg
// Brief    : Opcode encodings, FSM states and carry-init helper for addsub_seq
// Revision : 1.0
// ============================================================================
package addsub_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ADC = 2'b10;
    localparam logic [1:0] OP_SBC = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // ADD starts with carry 0, SUB with 1 (two's complement); ADC/SBC use cin.
    function automatic logic init_carry(input logic [1:0] op, input logic cin);
        return op[1] ? cin : op[0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/addsub_slice.sv
`default_nettype none
// ============================================================================
// Module   : addsub_slice
// Brief    : Combinational SLICE-bit adder on generate/propagate carries;
//            also exposes the carry into the slice MSB for overflow.
// Revision : 1.0
// ============================================================================
module addsub_slice #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             ci,
    output logic [SLICE-1:0] sum,
    output logic             co,
    output logic             c_msb_in
);

    logic [SLICE-1:0] w_g;
    logic [SLICE-1:0] w_p;
    logic [SLICE:0]   w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    always_comb begin
        w_c    = '0;
        w_c[0] = ci;
        for (int i = 0; i < SLICE; i++) begin
            w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
        end
    end

    assign sum      = w_p ^ w_c[SLICE-1:0];
    assign co       = w_c[SLICE];
    assign c_msb_in = w_c[SLICE-1];

endmodule
`default_nettype wire

// File: rtl/addsub_seq.sv
`default_nettype none
// ============================================================================
// Module   : addsub_seq
// Brief    : Multi-cycle WIDTH-bit add/subtract, SLICE bits per clock, with
//            valid/ready handshakes and carry/overflow/zero/negative flags.
// Revision : 1.0
// ============================================================================
module addsub_seq
    import addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic             cin,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NSLICE - 1);

    generate
        if ((SLICE < 1) || (WIDTH % SLICE != 0)) begin : g_bad_width
            $error("addsub_seq: WIDTH must be a non-zero multiple of SLICE");
        end
    endgenerate

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [NSLICE-1:0][SLICE-1:0]  r_x;
    logic [NSLICE-1:0][SLICE-1:0]  r_y;
    logic [NSLICE-1:0][SLICE-1:0]  r_s;
    logic [NSLICE-1:0][SLICE-1:0]  w_s_nxt;
    logic                          r_carry;
    logic [CNT_W-1:0]              r_cnt;
    logic                          r_cout;
    logic                          r_ovf;
    logic                          r_zero;
    logic                          r_neg;

    logic                          w_accept;
    logic                          w_run;
    logic                          w_last;
    logic [SLICE-1:0]              w_sum;
    logic                          w_co;
    logic                          w_cmsb;

    addsub_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a        (r_x[r_cnt]),
        .b        (r_y[r_cnt]),
        .ci       (r_carry),
        .sum      (w_sum),
        .co       (w_co),
        .c_msb_in (w_cmsb)
    );

    assign w_accept = (r_state == ST_IDLE) && in_valid;
    assign w_run    = (r_state == ST_RUN);
    assign w_last   = w_run && (r_cnt == C_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Full result as it will look after this cycle's slice write; used for zero.
    always_comb begin
        w_s_nxt        = r_s;
        w_s_nxt[r_cnt] = w_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x     <= '0;
            r_y     <= '0;
            r_s     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
            r_neg   <= 1'b0;
        end else if (w_accept) begin
            r_x     <= x;
            r_y     <= y ^ {WIDTH{op[0]}};
            r_carry <= init_carry(op, cin);
            r_cnt   <= '0;
        end else if (w_run) begin
            r_s[r_cnt] <= w_sum;
            r_carry    <= w_co;
            r_cnt      <= w_last ? '0 : r_cnt + 1'b1;
            if (w_last) begin
                r_cout <= w_co;
                r_ovf  <= w_cmsb ^ w_co;
                r_zero <= ~|w_s_nxt;
                r_neg  <= w_sum[SLICE-1];
            end
        end
    end

    assign s    = r_s;
    assign cout = r_cout;
    assign ovf  = r_ovf;
    assign zero = r_zero;
    assign neg  = r_neg;

endmodule
`default_nettype wire

// File: tb/tb_addsub_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_addsub_seq
// Brief    : Directed self-checking bench for addsub_seq (WIDTH=32).
// Revision : 1.0
// ============================================================================
module tb_addsub_seq;

    localparam int WIDTH  = 32;
    parameter  int SLICE  = 8;
    localparam int NSLICE = WIDTH / SLICE;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ADC = 2'b10;
    localparam logic [1:0] OP_SBC = 2'b11;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic             cin;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             neg;

    int n_cmp = 0;
    int n_err = 0;

    addsub_seq #(
        .WIDTH (WIDTH),
        .SLICE (SLICE)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .cin       (cin),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero),
        .neg       (neg)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Presents one operation, then scrambles the inputs and waits for out_valid.
    task automatic issue(input string name, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic c);
        int lat;
        @(negedge clk);
        check_val({name, ".in_ready"}, 64'(in_ready), 64'd1);
        op = o; x = a; y = b; cin = c; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        op = ~o; x = $urandom; y = $urandom; cin = ~c;
        lat = 0;
        while (!out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        check_val({name, ".latency"}, 64'(lat), 64'(NSLICE));
    endtask

    // flags packed as {cout, ovf, zero, neg}
    task automatic check_result(input string name, input logic [31:0] exp_s, input logic [3:0] exp_f);
        check_val({name, ".s"}, 64'(s), 64'(exp_s));
        check_val({name, ".flags"}, 64'({cout, ovf, zero, neg}), 64'(exp_f));
    endtask

    task automatic take(input string name);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_val({name, ".idle"}, 64'({out_valid, in_ready}), 64'b01);
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic c,
                          input logic [31:0] exp_s, input logic [3:0] exp_f);
        issue(name, o, a, b, c);
        check_result(name, exp_s, exp_f);
        take(name);
    endtask

    initial begin
        bit seen;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = OP_ADD; cin = 1'b0; x = '0; y = '0;
        repeat (2) @(negedge clk);
        check_val("reset.hs", 64'({in_ready, out_valid}), 64'b10);
        check_result("reset", 32'h0, 4'b0000);
        rst = 1'b0;

        run_op("add_wrap", OP_ADD, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 4'b1010);
        run_op("sub_ovf",  OP_SUB, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 4'b1100);
        run_op("sub_brw",  OP_SUB, 32'd5,         32'd7,         1'b0, 32'hFFFF_FFFE, 4'b0001);
        run_op("adc",      OP_ADC, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 4'b1010);
        run_op("sbc0",     OP_SBC, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 4'b0001);
        run_op("add_povf", OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 4'b0101);
        run_op("add_cin",  OP_ADD, 32'd2,         32'd3,         1'b1, 32'd5,         4'b0000);
        run_op("sub_cin",  OP_SUB, 32'd10,        32'd3,         1'b0, 32'd7,         4'b1000);
        run_op("sbc1",     OP_SBC, 32'd10,        32'd3,         1'b1, 32'd7,         4'b1000);
        run_op("adc_mid",  OP_ADC, 32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 4'b0000);

        // Back-pressure in DONE: result held, no accept even with in_valid high
        issue("hold", OP_ADD, 32'h10, 32'h20, 1'b0);
        check_result("hold", 32'h30, 4'b0000);
        op = OP_SUB; x = 32'h1234; y = 32'h1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("hold.hs", 64'({out_valid, in_ready}), 64'b10);
            check_result("hold.stable", 32'h30, 4'b0000);
        end
        in_valid = 1'b0;
        take("hold");
        run_op("after_hold", OP_SUB, 32'h1234, 32'h1, 1'b0, 32'h1233, 4'b1000);

        // Reset during the second RUN cycle aborts the operation
        @(negedge clk);
        op = OP_ADD; x = 32'h1234_5678; y = 32'h1111_1111; cin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("abort.hs", 64'({in_ready, out_valid}), 64'b10);
        check_result("abort", 32'h0, 4'b0000);
        seen = 1'b0;
        for (int i = 0; i < NSLICE + 3; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check_val("abort.no_out", 64'(seen), 64'd0);
        run_op("after_rst", OP_ADD, 32'hFFFF_0000, 32'h0001_0000, 1'b0, 32'h0000_0000, 4'b1010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
